id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register for the 5-stage RISC-V core. It is the successor of the fixed-width ID/EX latch and adds:
- valid tracking
- hold on stall
- bubble insertion on flush
- built-in load-use hazard detection with automatic bubble insertion
- saturating stall/bubble performance counters
It sits between the decode stage (register file, immediate generator, control MUX) and the EX stage (forwarding unit, ALU-source muxes, EX/MEM).

---
 rtl/id_ex_pipe_reg.sv | 167 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Captures decoded operands and controls for EX, tracks validity, holds on
// stall, inserts bubbles on flush or on a detected load-use hazard, and keeps
// saturating stall/bubble performance counters.
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   inst_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rd1_i,
    input  logic [XLEN-1:0]   rd2_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [XLEN-1:0]   inst_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [1:0]        wb_o,
    output logic [1:0]        m_o,
    output logic              alu_src_o,
    output logic [1:0]        alu_op_o,
    output logic [RA_W-1:0]   rs1_addr_o,
    output logic [RA_W-1:0]   rs2_addr_o,
    output logic [RA_W-1:0]   rd_addr_o,
    output logic              mem_read_o,
    output logic              load_use_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [1:0]      wb;
        logic [1:0]      m;
        logic            alu_src;
        logic [1:0]      alu_op;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd_addr;
        logic            mem_read;
    } ex_stage_t;

    // One action per edge, listed in priority order.
    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_STALL,
        ACT_BUBBLE,
        ACT_LOAD
    } action_e;

    ex_stage_t ex_q;
    ex_stage_t ex_d;
    ex_stage_t load_val;
    action_e   action;
    logic      stall_inc;
    logic      bubble_inc;

    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;

    assign id_rs1 = RA_W'(inst_i[19:15]);
    assign id_rs2 = RA_W'(inst_i[24:20]);
    assign id_rd  = RA_W'(inst_i[11:7]);

    // Load-use hazard: EX holds a valid load whose destination ID reads now.
    assign load_use_o = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) & valid_i &
                        ((ex_q.rd_addr == id_rs1) | (ex_q.rd_addr == id_rs2));

    // Select this cycle's action by priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        action = ACT_LOAD;
        if (flush_i)         action = ACT_FLUSH;
        else if (stall_i)    action = ACT_STALL;
        else if (load_use_o) action = ACT_BUBBLE;
    end

    // Build the normal-load value; controls are squashed for an invalid slot.
    always_comb begin
        load_val          = '0;
        load_val.valid    = valid_i;
        load_val.inst     = inst_i;
        load_val.pc       = pc_i;
        load_val.rs1_data = rd1_i;
        load_val.rs2_data = rd2_i;
        load_val.imm      = imm_i;
        load_val.rs1_addr = id_rs1;
        load_val.rs2_addr = id_rs2;
        load_val.rd_addr  = id_rd;
        if (valid_i) begin
            load_val.alu_op   = ctrl_i[6:5];
            load_val.alu_src  = ctrl_i[4];
            load_val.m        = ctrl_i[3:2];
            load_val.wb       = ctrl_i[1:0];
            load_val.mem_read = ctrl_i[3];
        end
    end

    // Next stage contents and counter increment requests.
    always_comb begin
        ex_d       = ex_q;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        unique case (action)
            ACT_FLUSH, ACT_BUBBLE: begin
                ex_d       = '0;
                bubble_inc = 1'b1;
            end
            ACT_STALL: stall_inc = 1'b1;
            ACT_LOAD: begin
                ex_d       = load_val;
                bubble_inc = ~valid_i;
            end
            default: ex_d = ex_q;
        endcase
    end

    // Stage register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_i) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_inc && (stall_cnt_o != '1))   stall_cnt_o  <= stall_cnt_o + 1'b1;
            if (bubble_inc && (bubble_cnt_o != '1)) bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

    assign valid_o    = ex_q.valid;
    assign inst_o     = ex_q.inst;
    assign pc_o       = ex_q.pc;
    assign rs1_data_o = ex_q.rs1_data;
    assign rs2_data_o = ex_q.rs2_data;
    assign imm_o      = ex_q.imm;
    assign wb_o       = ex_q.wb;
    assign m_o        = ex_q.m;
    assign alu_src_o  = ex_q.alu_src;
    assign alu_op_o   = ex_q.alu_op;
    assign rs1_addr_o = ex_q.rs1_addr;
    assign rs2_addr_o = ex_q.rs2_addr;
    assign rd_addr_o  = ex_q.rd_addr;
    assign mem_read_o = ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: each directed step pushes the outputs
// expected during that cycle; a monitor pops and compares on the falling edge.
module tb_id_ex_pipe_reg;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    localparam logic [31:0] ADD  = 32'h00A28233; // add x4,x5,x10
    localparam logic [31:0] LW   = 32'h0002A303; // lw  x6,0(x5)
    localparam logic [31:0] DEP  = 32'h001303B3; // add x7,x6,x1
    localparam logic [31:0] DEP2 = 32'h006083B3; // add x7,x1,x6
    localparam logic [31:0] LW0  = 32'h0002A003; // lw  x0,0(x5)
    localparam logic [31:0] DEP0 = 32'h001003B3; // add x7,x0,x1

    logic              clk_i = 1'b0;
    logic              rst_i, stall_i, flush_i, valid_i;
    logic [XLEN-1:0]   inst_i, pc_i, rd1_i, rd2_i, imm_i;
    logic [6:0]        ctrl_i;
    logic              valid_o, alu_src_o, mem_read_o, load_use_o;
    logic [XLEN-1:0]   inst_o, pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [1:0]        wb_o, m_o, alu_op_o;
    logic [RA_W-1:0]   rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [CNT_W-1:0]  stall_cnt_o, bubble_cnt_o;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [6:0]  ctrl;
        logic        lu;
        int          scnt;
        int          bcnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    id_ex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(7), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .inst_i(inst_i), .pc_i(pc_i), .rd1_i(rd1_i),
        .rd2_i(rd2_i), .imm_i(imm_i), .ctrl_i(ctrl_i), .valid_o(valid_o),
        .inst_o(inst_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .imm_o(imm_o), .wb_o(wb_o), .m_o(m_o),
        .alu_src_o(alu_src_o), .alu_op_o(alu_op_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .mem_read_o(mem_read_o),
        .load_use_o(load_use_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                input logic [6:0] ctrl, input logic lu, input int s, input int b);
        exp_t e;
        e.valid = v; e.inst = inst; e.pc = pc; e.ctrl = ctrl;
        e.lu = lu; e.scnt = s; e.bcnt = b;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what must be visible during it.
    task automatic step(input logic rst, input logic fl, input logic st, input logic v,
                        input logic [31:0] inst, input logic [31:0] pc, input logic [6:0] ctrl,
                        input exp_t e);
        rst_i = rst; flush_i = fl; stall_i = st; valid_i = v;
        inst_i = inst; pc_i = pc; ctrl_i = ctrl;
        rd1_i = pc ^ inst; rd2_i = pc + inst; imm_i = pc - inst;
        sb.push_back(e);
        @(posedge clk_i); #1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid_o",      32'(valid_o),      32'(e.valid));
                check("inst_o",       inst_o,            e.inst);
                check("pc_o",         pc_o,              e.pc);
                check("rs1_data_o",   rs1_data_o,        e.pc ^ e.inst);
                check("rs2_data_o",   rs2_data_o,        e.pc + e.inst);
                check("imm_o",        imm_o,             e.pc - e.inst);
                check("wb_o",         32'(wb_o),         32'(e.ctrl[1:0]));
                check("m_o",          32'(m_o),          32'(e.ctrl[3:2]));
                check("alu_src_o",    32'(alu_src_o),    32'(e.ctrl[4]));
                check("alu_op_o",     32'(alu_op_o),     32'(e.ctrl[6:5]));
                check("mem_read_o",   32'(mem_read_o),   32'(e.ctrl[3]));
                check("rs1_addr_o",   32'(rs1_addr_o),   32'(e.inst[19:15]));
                check("rs2_addr_o",   32'(rs2_addr_o),   32'(e.inst[24:20]));
                check("rd_addr_o",    32'(rd_addr_o),    32'(e.inst[11:7]));
                check("load_use_o",   32'(load_use_o),   32'(e.lu));
                check("stall_cnt_o",  32'(stall_cnt_o),  32'(e.scnt));
                check("bubble_cnt_o", 32'(bubble_cnt_o), 32'(e.bcnt));
            end
        end
    end

    initial begin
        int drain;
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        inst_i = '0; pc_i = '0; rd1_i = '0; rd2_i = '0; imm_i = '0; ctrl_i = '0;
        @(posedge clk_i); #1;

        // Reset, first load, a stall, then reset asserted between edges.
        step(0, 0, 0, 0, 32'h0, 32'h0,  7'h00, mk(0, 32'h0, 32'h0,  7'h00, 0, 0, 0));
        step(1, 0, 0, 1, ADD,   32'h40, 7'h41, mk(0, 32'h0, 32'h0,  7'h00, 0, 0, 0));
        step(1, 0, 1, 1, LW,    32'h44, 7'h1B, mk(1, ADD,   32'h40, 7'h41, 0, 0, 0));
        step(1, 0, 0, 1, ADD,   32'h40, 7'h41, mk(1, ADD,   32'h40, 7'h41, 0, 1, 0));
        step(0, 0, 0, 1, ADD,   32'h40, 7'h41, mk(0, 32'h0, 32'h0,  7'h00, 0, 0, 0));
        step(1, 0, 0, 1, ADD,   32'h40, 7'h41, mk(0, 32'h0, 32'h0,  7'h00, 0, 0, 0));

        // Load-use on rs1, replay, then rd=x0 (no hazard), then load-use on rs2.
        step(1, 0, 0, 1, LW,    32'h44, 7'h1B, mk(1, ADD,   32'h40, 7'h41, 0, 0, 0));
        step(1, 0, 0, 1, DEP,   32'h48, 7'h41, mk(1, LW,    32'h44, 7'h1B, 1, 0, 0));
        step(1, 0, 0, 1, DEP,   32'h48, 7'h41, mk(0, 32'h0, 32'h0,  7'h00, 0, 0, 1));
        step(1, 0, 0, 1, LW0,   32'h4C, 7'h1B, mk(1, DEP,   32'h48, 7'h41, 0, 0, 1));
        step(1, 0, 0, 1, DEP0,  32'h50, 7'h41, mk(1, LW0,   32'h4C, 7'h1B, 0, 0, 1));
        step(1, 0, 0, 1, LW,    32'h54, 7'h1B, mk(1, DEP0,  32'h50, 7'h41, 0, 0, 1));
        step(1, 0, 0, 1, DEP2,  32'h58, 7'h41, mk(1, LW,    32'h54, 7'h1B, 1, 0, 1));
        step(1, 0, 0, 1, DEP2,  32'h58, 7'h41, mk(0, 32'h0, 32'h0,  7'h00, 0, 0, 2));

        // Three stall cycles with changing inputs, then flush overriding stall.
        step(1, 0, 1, 1, ADD,   32'h60, 7'h1B, mk(1, DEP2,  32'h58, 7'h41, 0, 0, 2));
        step(1, 0, 1, 0, LW,    32'h64, 7'h7F, mk(1, DEP2,  32'h58, 7'h41, 0, 1, 2));
        step(1, 0, 1, 1, DEP,   32'h68, 7'h00, mk(1, DEP2,  32'h58, 7'h41, 0, 2, 2));
        step(1, 1, 1, 1, ADD,   32'h6C, 7'h41, mk(1, DEP2,  32'h58, 7'h41, 0, 3, 2));

        // Invalid load: data captured, controls squashed, bubble counted.
        step(1, 0, 0, 0, ADD,   32'h70, 7'h7F, mk(0, 32'h0, 32'h0,  7'h00, 0, 3, 3));

        // Twenty stall cycles: stall counter saturates at 15.
        for (int k = 0; k < 20; k++)
            step(1, 0, 1, 0, 32'h0, 32'h0, 7'h00,
                 mk(0, ADD, 32'h70, 7'h00, 0, (3 + k > 15) ? 15 : 3 + k, 4));
        step(1, 0, 0, 0, 32'h0, 32'h0, 7'h00, mk(0, ADD,   32'h70, 7'h00, 0, 15, 4));
        step(1, 0, 0, 0, 32'h0, 32'h0, 7'h00, mk(0, 32'h0, 32'h0,  7'h00, 0, 15, 5));

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk_i);
            drain++;
        end
        n_checks++;
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
